trap_ctrl: RTL and testbench

Machine-mode trap sequencer that sits directly upstream of csr_reg. It arbitrates synchronous exceptions, pending machine interrupts and MRET requests from the core pipeline. It drives csr_reg's trap write interface (trap_mie/trap_mpie/trap_pc_in/trap_int/trap_cause/trap_val/trap_wr_en) and issues a PC redirect to fetch.

---
 rtl/trap_ctrl_if.sv | 60 ++++++
 rtl/trap_ctrl.sv | 143 ++++++++++++++
 tb/tb_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR/fetch signal bundle for trap_ctrl; the core side drives it through the master modport,
// and trap_ctrl connects to it through the slave modport.
interface trap_ctrl_if #(
    parameter int CAUSE_W = 31
);
    // pipeline requests
    logic               exc_valid;
    logic [CAUSE_W-1:0] exc_cause;
    logic [31:0]        exc_pc;
    logic [31:0]        exc_val;
    logic               mret_valid;
    logic               int_window;
    logic [31:0]        int_pc;

    // csr_reg state
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic               mie_msie;
    logic               mie_mtie;
    logic               mie_meie;
    logic               mip_msip;
    logic               mip_mtip;
    logic               mip_meip;
    logic [31:0]        mtvec;
    logic [31:0]        mepc;

    // csr_reg trap / mret write port
    logic               trap_mie;
    logic               trap_mpie;
    logic [31:0]        trap_pc_in;
    logic               trap_int;
    logic [CAUSE_W-1:0] trap_cause;
    logic [31:0]        trap_val;
    logic               trap_wr_en;
    logic               mret_wr_en;
    logic               mret_mie;
    logic               mret_mpie;

    // fetch redirect
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready;
    logic               busy;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_val, mret_valid, int_window, int_pc,
        output mstatus_mie, mstatus_mpie, mie_msie, mie_mtie, mie_meie,
        output mip_msip, mip_mtip, mip_meip, mtvec, mepc, redirect_ready,
        input  trap_mie, trap_mpie, trap_pc_in, trap_int, trap_cause, trap_val, trap_wr_en,
        input  mret_wr_en, mret_mie, mret_mpie, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_val, mret_valid, int_window, int_pc,
        input  mstatus_mie, mstatus_mpie, mie_msie, mie_mtie, mie_meie,
        input  mip_msip, mip_mtip, mip_meip, mtvec, mepc, redirect_ready,
        output trap_mie, trap_mpie, trap_pc_in, trap_int, trap_cause, trap_val, trap_wr_en,
        output mret_wr_en, mret_mie, mret_mpie, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer feeding csr_reg; TRAP_VECTORED_EN enables vectored interrupt targets.
// Accept at edge N, csr strobe in cycle N+1, redirect from N+2 held until redirect_ready; busy stalls the pipe.
module trap_ctrl #(
    parameter int CAUSE_W = 31
) (
    input  logic         clk,
    input  logic         reset,
    trap_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WRITE    = 2'd1;
    localparam logic [1:0] ST_MRET_WR  = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic               pend_msi;
    logic               pend_mti;
    logic               pend_mei;
    logic               int_take;
    logic               accept_trap;
    logic               accept_mret;

    logic               acc_int;
    logic [CAUSE_W-1:0] acc_cause;
    logic [31:0]        acc_pc;
    logic [31:0]        acc_val;
    logic [31:0]        acc_target;
    logic [31:0]        trap_base;

    logic               cap_int;
    logic [CAUSE_W-1:0] cap_cause;
    logic [31:0]        cap_pc;
    logic [31:0]        cap_val;
    logic [31:0]        cap_target;
    logic               cap_mstat;

    always_comb begin
        pend_msi    = bus.mie_msie & bus.mip_msip;
        pend_mti    = bus.mie_mtie & bus.mip_mtip;
        pend_mei    = bus.mie_meie & bus.mip_meip;
        int_take    = bus.int_window & bus.mstatus_mie & (pend_msi | pend_mti | pend_mei);
        accept_trap = (state == ST_IDLE) & (bus.exc_valid | int_take);
        accept_mret = (state == ST_IDLE) & ~bus.exc_valid & ~int_take & bus.mret_valid;
    end

    // Exceptions win over interrupts; among interrupts MEI > MSI > MTI.
    always_comb begin
        acc_int   = ~bus.exc_valid;
        acc_cause = bus.exc_cause;
        acc_pc    = bus.exc_pc;
        acc_val   = bus.exc_val;
        if (!bus.exc_valid) begin
            acc_pc  = bus.int_pc;
            acc_val = 32'd0;
            if (pend_mei) begin
                acc_cause = CAUSE_W'(11);
            end else if (pend_msi) begin
                acc_cause = CAUSE_W'(3);
            end else begin
                acc_cause = CAUSE_W'(7);
            end
        end
    end

    always_comb begin
        trap_base  = {bus.mtvec[31:2], 2'b00};
        acc_target = trap_base;
`ifdef TRAP_VECTORED_EN
        if ((bus.mtvec[1:0] == 2'b01) && acc_int) begin
            acc_target = trap_base + (32'(acc_cause) << 2);
        end
`else
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_trap) begin
                    state_nxt = ST_WRITE;
                end else if (accept_mret) begin
                    state_nxt = ST_MRET_WR;
                end
            end
            ST_WRITE:    state_nxt = ST_REDIRECT;
            ST_MRET_WR:  state_nxt = ST_REDIRECT;
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // cap_mstat holds mstatus.MIE for traps and mstatus.MPIE for MRET, both sampled at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap_int    <= 1'b0;
            cap_cause  <= '0;
            cap_pc     <= 32'd0;
            cap_val    <= 32'd0;
            cap_target <= 32'd0;
            cap_mstat  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_trap) begin
                cap_int    <= acc_int;
                cap_cause  <= acc_cause;
                cap_pc     <= acc_pc;
                cap_val    <= acc_val;
                cap_target <= acc_target;
                cap_mstat  <= bus.mstatus_mie;
            end else if (accept_mret) begin
                cap_target <= {bus.mepc[31:2], 2'b00};
                cap_mstat  <= bus.mstatus_mpie;
            end
        end
    end

    // Payloads are gated by their strobe so csr_reg and fetch see zeros whenever idle.
    assign bus.trap_wr_en     = (state == ST_WRITE);
    assign bus.trap_mie       = 1'b0;
    assign bus.trap_mpie      = bus.trap_wr_en & cap_mstat;
    assign bus.trap_int       = bus.trap_wr_en & cap_int;
    assign bus.trap_cause     = bus.trap_wr_en ? cap_cause : '0;
    assign bus.trap_pc_in     = bus.trap_wr_en ? cap_pc : 32'd0;
    assign bus.trap_val       = bus.trap_wr_en ? cap_val : 32'd0;

    assign bus.mret_wr_en     = (state == ST_MRET_WR);
    assign bus.mret_mie       = bus.mret_wr_en & cap_mstat;
    assign bus.mret_mpie      = bus.mret_wr_en;

    assign bus.redirect_valid = (state == ST_REDIRECT);
    assign bus.redirect_pc    = bus.redirect_valid ? cap_target : 32'd0;
    assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected csr writes and redirects are queued at stimulus time and
// popped when the DUT strobes.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] VEC_MTI_TARGET = 32'h0000_101C;
`else
    localparam logic [31:0] VEC_MTI_TARGET = 32'h0000_1000;
`endif

    typedef struct {
        bit          is_mret;
        bit          intr;
        logic [30:0] cause;
        logic [31:0] pc;
        logic [31:0] val;
        logic [31:0] target;
        bit          mst;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_trap(input bit intr, input logic [30:0] cause, input logic [31:0] pc,
                               input logic [31:0] val, input logic [31:0] target, input bit mst);
        exp_t e;
        e.is_mret = 1'b0; e.intr = intr; e.cause = cause; e.pc = pc;
        e.val = val; e.target = target; e.mst = mst;
        sb.push_back(e);
    endtask

    task automatic expect_mret(input logic [31:0] target, input bit mst);
        exp_t e;
        e.is_mret = 1'b1; e.intr = 1'b0; e.cause = '0; e.pc = '0;
        e.val = '0; e.target = target; e.mst = mst;
        sb.push_back(e);
    endtask

    // One-cycle request pulse; returns at the negedge right after the accepting posedge.
    task automatic fire(input bit exc, input bit intw, input bit mret);
        bus.exc_valid  = exc;
        bus.int_window = intw;
        bus.mret_valid = mret;
        @(negedge clk);
        bus.exc_valid  = 1'b0;
        bus.int_window = 1'b0;
        bus.mret_valid = 1'b0;
    endtask

    task automatic run_txn(input int stall);
        exp_t e;
        chk("sb_depth", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.is_mret) begin
            chk("mret_wr_en", bus.mret_wr_en, 1);
            chk("mret_mie", bus.mret_mie, e.mst);
            chk("mret_mpie", bus.mret_mpie, 1);
            chk("mret_no_trap_wr", bus.trap_wr_en, 0);
        end else begin
            chk("trap_wr_en", bus.trap_wr_en, 1);
            chk("trap_no_mret_wr", bus.mret_wr_en, 0);
            chk("trap_mie", bus.trap_mie, 0);
            chk("trap_mpie", bus.trap_mpie, e.mst);
            chk("trap_int", bus.trap_int, e.intr);
            chk("trap_cause", bus.trap_cause, e.cause);
            chk("trap_pc_in", bus.trap_pc_in, e.pc);
            chk("trap_val", bus.trap_val, e.val);
        end
        chk("busy_in_write", bus.busy, 1);
        chk("no_early_redirect", bus.redirect_valid, 0);
        @(negedge clk);
        for (int i = 0; i < stall; i++) begin
            chk("stall_redirect_valid", bus.redirect_valid, 1);
            chk("stall_redirect_pc", bus.redirect_pc, e.target);
            chk("stall_no_wr", bus.trap_wr_en, 0);
            bus.exc_valid = (i == 0);
            bus.exc_cause = 31'd9;
            @(negedge clk);
        end
        bus.exc_valid      = 1'b0;
        bus.redirect_ready = 1'b1;
        chk("redirect_valid", bus.redirect_valid, 1);
        chk("redirect_pc", bus.redirect_pc, e.target);
        chk("redirect_no_wr", bus.trap_wr_en | bus.mret_wr_en, 0);
        @(negedge clk);
        chk("redirect_done", bus.redirect_valid, 0);
        chk("idle_after", bus.busy, 0);
        chk("no_extra_wr", bus.trap_wr_en | bus.mret_wr_en, 0);
    endtask

    task automatic set_int(input bit meip, input bit msip, input bit mtip);
        bus.mip_meip = meip;
        bus.mip_msip = msip;
        bus.mip_mtip = mtip;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trap_wr_en"}, bus.trap_wr_en, 0);
        chk({tag, "_mret_wr_en"}, bus.mret_wr_en, 0);
        chk({tag, "_mret_mpie"}, bus.mret_mpie, 0);
        chk({tag, "_redirect_valid"}, bus.redirect_valid, 0);
        chk({tag, "_redirect_pc"}, bus.redirect_pc, 0);
        chk({tag, "_trap_cause"}, bus.trap_cause, 0);
        chk({tag, "_trap_pc_in"}, bus.trap_pc_in, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.exc_valid      = 1'b0;
        bus.exc_cause      = '0;
        bus.exc_pc         = 32'd0;
        bus.exc_val        = 32'd0;
        bus.mret_valid     = 1'b0;
        bus.int_window     = 1'b0;
        bus.int_pc         = 32'd0;
        bus.mstatus_mie    = 1'b1;
        bus.mstatus_mpie   = 1'b0;
        bus.mie_msie       = 1'b1;
        bus.mie_mtie       = 1'b1;
        bus.mie_meie       = 1'b1;
        set_int(1'b0, 1'b0, 1'b0);
        bus.mtvec          = 32'h0000_0004;
        bus.mepc           = 32'd0;
        bus.redirect_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: synchronous exception
        bus.exc_cause = 31'd2; bus.exc_pc = 32'h8AB4; bus.exc_val = 32'hFFEEDD11;
        expect_trap(1'b0, 31'd2, 32'h8AB4, 32'hFFEEDD11, 32'h4, 1'b1);
        fire(1'b1, 1'b0, 1'b0);
        run_txn(0);

        // 2: interrupt priority
        bus.int_pc = 32'h8A9C;
        set_int(1'b1, 1'b1, 1'b1);
        expect_trap(1'b1, 31'd11, 32'h8A9C, 32'h0, 32'h4, 1'b1);
        fire(1'b0, 1'b1, 1'b0);
        run_txn(0);
        set_int(1'b0, 1'b1, 1'b1);
        expect_trap(1'b1, 31'd3, 32'h8A9C, 32'h0, 32'h4, 1'b1);
        fire(1'b0, 1'b1, 1'b0);
        run_txn(0);
        bus.mstatus_mie = 1'b0;
        set_int(1'b1, 1'b1, 1'b1);
        fire(1'b0, 1'b1, 1'b0);
        chk("masked_int_no_wr", bus.trap_wr_en, 0);
        chk("masked_int_busy", bus.busy, 0);
        @(negedge clk);
        chk("masked_int_no_redirect", bus.redirect_valid, 0);
        bus.mstatus_mie = 1'b1;

        // 3: exception beats a simultaneous pending MTI
        set_int(1'b0, 1'b0, 1'b1);
        bus.exc_cause = 31'd5; bus.exc_pc = 32'h3000; bus.exc_val = 32'h55;
        expect_trap(1'b0, 31'd5, 32'h3000, 32'h55, 32'h4, 1'b1);
        fire(1'b1, 1'b1, 1'b0);
        run_txn(0);
        set_int(1'b0, 1'b0, 1'b0);

        // 4: MRET, including a misaligned mepc
        bus.mstatus_mpie = 1'b1; bus.mepc = 32'h8A9C;
        expect_mret(32'h8A9C, 1'b1);
        fire(1'b0, 1'b0, 1'b1);
        run_txn(0);
        bus.mstatus_mpie = 1'b0; bus.mepc = 32'h1236;
        expect_mret(32'h1234, 1'b0);
        fire(1'b0, 1'b0, 1'b1);
        run_txn(0);

        // 5a: redirect backpressure; a new exception while busy is dropped
        bus.mstatus_mie = 1'b0;
        bus.exc_cause = 31'd4; bus.exc_pc = 32'h4440; bus.exc_val = 32'h1;
        bus.redirect_ready = 1'b0;
        expect_trap(1'b0, 31'd4, 32'h4440, 32'h1, 32'h4, 1'b0);
        fire(1'b1, 1'b0, 1'b0);
        run_txn(3);
        bus.mstatus_mie = 1'b1;

        // 5b: reset asserted while the csr write strobe is up
        bus.exc_cause = 31'd6; bus.exc_pc = 32'h5550; bus.exc_val = 32'h2;
        expect_trap(1'b0, 31'd6, 32'h5550, 32'h2, 32'h4, 1'b1);
        fire(1'b1, 1'b0, 1'b0);
        begin
            exp_t e;
            e = sb.pop_front();
            chk("pre_reset_wr_en", bus.trap_wr_en, 1);
            chk("pre_reset_cause", bus.trap_cause, e.cause);
        end
        #1 reset = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_reset_no_wr", bus.trap_wr_en, 0);
            chk("post_reset_no_redirect", bus.redirect_valid, 0);
            chk("post_reset_idle", bus.busy, 0);
        end

        // 6: vectored mtvec, interrupt vs exception
        bus.mtvec = 32'h0000_1001;
        bus.int_pc = 32'h2000;
        set_int(1'b0, 1'b0, 1'b1);
        expect_trap(1'b1, 31'd7, 32'h2000, 32'h0, VEC_MTI_TARGET, 1'b1);
        fire(1'b0, 1'b1, 1'b0);
        run_txn(0);
        set_int(1'b0, 1'b0, 1'b0);
        bus.exc_cause = 31'd2; bus.exc_pc = 32'h2004; bus.exc_val = 32'h0;
        expect_trap(1'b0, 31'd2, 32'h2004, 32'h0, 32'h1000, 1'b1);
        fire(1'b1, 1'b0, 1'b0);
        run_txn(0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
